// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, a one-entry skid buffer,
// and synchronous flush with a saturating count of discarded entries.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 103,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } stateT;

    stateT             stateQ, stateD;
    logic [DATA_W-1:0] mainQ, mainD;
    logic [DATA_W-1:0] skidQ, skidD;
    logic [CNT_W-1:0]  dropQ, dropD;
    logic [1:0]        dropInc;
    logic [CNT_W:0]    dropSum;
    logic              inReadyQ, outValidQ;
    logic [1:0]        occupancyQ;
    logic              inXfer, outXfer;

    assign inXfer  = in_valid & inReadyQ;
    assign outXfer = outValidQ & out_ready;

    always_comb begin
        stateD  = stateQ;
        mainD   = mainQ;
        skidD   = skidQ;
        dropInc = 2'd0;
        if (flush) begin
            // A main entry delivered in the flush cycle is not a discard.
            stateD = StEmpty;
            unique case (stateQ)
                StOne:   dropInc = outXfer ? 2'd0 : 2'd1;
                StFull:  dropInc = outXfer ? 2'd1 : 2'd2;
                default: dropInc = 2'd0;
            endcase
        end else begin
            unique case (stateQ)
                StEmpty: begin
                    if (inXfer) begin
                        stateD = StOne;
                        mainD  = in_data;
                    end
                end
                StOne: begin
                    if (inXfer && outXfer) begin
                        mainD = in_data;
                    end else if (inXfer) begin
                        stateD = StFull;
                        skidD  = in_data;
                    end else if (outXfer) begin
                        stateD = StEmpty;
                    end
                end
                StFull: begin
                    if (outXfer) begin
                        stateD = StOne;
                        mainD  = skidQ;
                    end
                end
                default: stateD = StEmpty;
            endcase
        end
    end

    always_comb begin
        dropSum = {1'b0, dropQ} + {{(CNT_W - 1){1'b0}}, dropInc};
        dropD   = dropSum[CNT_W] ? {CNT_W{1'b1}} : dropSum[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ     <= StEmpty;
            mainQ      <= '0;
            skidQ      <= '0;
            dropQ      <= '0;
            inReadyQ   <= 1'b1;
            outValidQ  <= 1'b0;
            occupancyQ <= 2'd0;
        end else begin
            stateQ     <= stateD;
            mainQ      <= mainD;
            skidQ      <= skidD;
            dropQ      <= dropD;
            inReadyQ   <= (stateD != StFull);
            outValidQ  <= (stateD != StEmpty);
            occupancyQ <= (stateD == StFull) ? 2'd2 : ((stateD == StOne) ? 2'd1 : 2'd0);
        end
    end

    assign in_ready   = inReadyQ;
    assign out_valid  = outValidQ;
    assign out_data   = mainQ;
    assign occupancy  = occupancyQ;
    assign drop_count = dropQ;

`ifndef SYNTHESIS
    // Handshake flags must always agree with the state encoding.
    assertReadyMatchesState : assert property (@(posedge clock) disable iff (!reset)
        inReadyQ == (stateQ != StFull));
    assertValidMatchesState : assert property (@(posedge clock) disable iff (!reset)
        outValidQ == (stateQ != StEmpty));
    assertStableUnderStall : assert property (@(posedge clock) disable iff (!reset)
        (outValidQ && !out_ready && !flush) |=> (outValidQ && $stable(mainQ)));
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based model;
// a second instance with a 2-bit counter exercises drop_count saturation.
module tb_pipe_stage_skid;

    localparam int DW = 103;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   drop_count;

    logic          in_ready2, out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occupancy2;
    logic [1:0]    drop_count2;

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(2)) dutSat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .drop_count(drop_count2)
    );

    always #5 clock = ~clock;

    // Behavioural model: a FIFO of at most two entries plus discard counters.
    logic [DW-1:0] q[$];
    logic [DW-1:0] lastFront = '0;
    int            cnt16 = 0;
    int            cnt2 = 0;
    int            checks = 0;
    int            errors = 0;
    bit            checkEn = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bit inX, outX;
        int d;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                q.delete();
                lastFront = '0;
                cnt16 = 0;
                cnt2 = 0;
            end else begin
                inX  = in_valid && (q.size() < 2);
                outX = out_ready && (q.size() > 0);
                if (flush) begin
                    d = q.size() - (outX ? 1 : 0);
                    cnt16 = (cnt16 + d > 65535) ? 65535 : cnt16 + d;
                    cnt2  = (cnt2 + d > 3) ? 3 : cnt2 + d;
                    q.delete();
                end else begin
                    if (outX) void'(q.pop_front());
                    if (inX) q.push_back(in_data);
                end
                if (q.size() > 0) lastFront = q[0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (checkEn) begin
                chk("in_ready", in_ready, q.size() < 2);
                chk("out_valid", out_valid, q.size() > 0);
                chk("out_data", out_data, (q.size() > 0) ? q[0] : lastFront);
                chk("occupancy", occupancy, 128'(q.size()));
                chk("drop_count", drop_count, 128'(cnt16));
                chk("drop_count_sat", drop_count2, 128'(cnt2));
            end
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic chkReset(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_occupancy"}, occupancy, 2'd0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_drop_count"}, drop_count, '0);
        chk({tag, "_drop_count_sat"}, drop_count2, '0);
    endtask

    localparam logic [DW-1:0] A = 'hA1;
    localparam logic [DW-1:0] B = 'hB2;
    localparam logic [DW-1:0] C = 'hC3;
    localparam logic [DW-1:0] D = 'hD4;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chkReset("reset");
        #2 reset = 1'b1;
        checkEn = 1'b1;

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DW'(i), 1'b1, 1'b0);
            chk("stream_data", out_data, 128'(i));
            chk("stream_occ", occupancy, 2'd1);
            chk("stream_ready", in_ready, 1'b1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("stream_drained", out_valid, 1'b0);

        // Back-pressure
        cyc(1'b1, A, 1'b0, 1'b0);
        chk("bp_a_out", out_data, A);
        cyc(1'b1, B, 1'b0, 1'b0);
        chk("bp_full_ready", in_ready, 1'b0);
        chk("bp_full_occ", occupancy, 2'd2);
        cyc(1'b1, C, 1'b0, 1'b0);
        chk("bp_c_rejected_occ", occupancy, 2'd2);
        chk("bp_a_held", out_data, A);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp_b_out", out_data, B);
        chk("bp_ready_back", in_ready, 1'b1);
        cyc(1'b1, C, 1'b1, 1'b0);
        chk("bp_c_out", out_data, C);
        chk("bp_c_occ", occupancy, 2'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", occupancy, 2'd0);

        // Flush in FULL with D presented
        cyc(1'b1, A, 1'b0, 1'b0);
        cyc(1'b1, B, 1'b0, 1'b0);
        cyc(1'b1, D, 1'b0, 1'b1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_occ", occupancy, 2'd0);
        chk("flush_ready", in_ready, 1'b1);
        chk("flush_drop", drop_count, 16'd2);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush with out_xfer in FULL
        cyc(1'b1, A, 1'b0, 1'b0);
        cyc(1'b1, B, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("flush_xfer_drop", drop_count, 16'd3);
        chk("flush_xfer_drop_sat", drop_count2, 2'd3);

        // Saturation of the 2-bit counter
        repeat (3) begin
            cyc(1'b1, A, 1'b0, 1'b0);
            cyc(1'b1, B, 1'b0, 1'b0);
            cyc(1'b0, '0, 1'b0, 1'b1);
        end
        chk("sat_drop", drop_count2, 2'd3);
        chk("sat_wide_drop", drop_count, 16'd9);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while FULL
        cyc(1'b1, A, 1'b0, 1'b0);
        cyc(1'b1, B, 1'b0, 1'b0);
        chk("pre_reset_occ", occupancy, 2'd2);
        #2 reset = 1'b0;
        #1;
        chkReset("async");
        @(posedge clock);
        #3 reset = 1'b1;
        cyc(1'b1, DW'('hABC), 1'b1, 1'b0);
        chk("post_reset_data", out_data, DW'('hABC));
        chk("post_reset_valid", out_valid, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("post_reset_drained", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor to our fixed-payload stage registers: the stage payload is generic, the stage sustains one transfer per cycle under back-pressure, and it supports flush with a discard counter. It sits between any two pipeline stages, for example MEM→WB or EX→MEM, in place of an enable-gated register.

## Interface
- DATA_W, 103: payload width. The default is the MEM/WB bundle: instr 32 + RegWrite 1 + MemToReg 1 + load data 32 + ALU result 32 + dest reg 5.
- CNT_W, 16: width of the discard counter.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered, equals state != FULL.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output payload valid; registered.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  output payload; registered.
- occupancy  out  2  entries held (0–2).
- drop_count  out  CNT_W  entries discarded by flush; saturating.

## Operation
- Storage is a main register (drives out_data) and a skid register.
- The state machine has three states: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
- Transfer definitions:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
- Transitions when flush is low:
  - EMPTY: in_xfer → ONE, main <= in_data. Otherwise stay in EMPTY.
  - ONE:
    - in_xfer & out_xfer → ONE, main <= in_data.
    - in_xfer & !out_xfer → FULL, skid <= in_data.
    - !in_xfer & out_xfer → EMPTY.
    - Otherwise hold.
  - FULL: in_ready=0, so in_xfer is impossible. out_xfer → ONE, main <= skid. Otherwise hold.
- Flush:
  - Next state is EMPTY regardless of in_valid, out_ready or current state.
  - Any in_data presented in the flush cycle is dropped, even if in_ready=1.
  - out_xfer in the flush cycle still counts as delivered downstream.
- drop_count increments in the flush cycle by the number of entries discarded:
  - 0 in EMPTY, 1 in ONE, 2 in FULL.
  - If out_xfer also occurs in that cycle, the delivered main entry is not counted (ONE adds 0, FULL adds 1).
  - The count saturates at 2^CNT_W−1 and never wraps.
- Payload registers load only on the transfers listed above. They are otherwise held, including while a stage is idle. Payload is not zeroed on flush.
- The register order is preserved: skid data always leaves after main data.

## Timing
- Reset (reset=0, asynchronous, independent of clock):
  - out_valid=0, in_ready=1, occupancy=0, out_data=0, drop_count=0.
  - Skid register is cleared to 0 and state is EMPTY.
- Reset asserted mid-transfer: all state is lost, with no partial update.
- First edge after release: normal operation.
- Latency: in_xfer at edge N makes the payload visible on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one transfer per cycle while out_ready=1.
- in_ready depends only on registered state, never combinationally on out_ready or in_valid.
- out_valid and out_data are stable while out_valid=1 & out_ready=0; they change only on out_xfer or flush.
- in_ready falls in the cycle after the skid fills. It rises in the cycle after an out_xfer in FULL, or after a flush.
- occupancy reflects the post-edge state.

## Test plan
- **Streaming:** reset, then 8 back-to-back payloads 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, each one cycle after input; in_ready stays 1; occupancy stays 1.
- **Back-pressure:**
  - Send A, B, C with out_ready=0.
  - Expect A held on output, B in the skid, in_ready=0 after B, and C not accepted.
  - Raise out_ready → A, B, C delivered in order with no loss or duplication.
- **Flush in FULL:** hold A, B with out_ready=0, then flush=1 with in_valid=1 (D) → next cycle out_valid=0, occupancy=0, in_ready=1, drop_count=2, and D never appears.
- **Flush with out_xfer in FULL:** out_ready=1 in the flush cycle → A is delivered and drop_count increases by 1.
- **Saturation:** with CNT_W=2, perform 3 flushes each holding 2 entries → drop_count = 3 and stays 3.
- **Async reset:** assert reset between clock edges while FULL → outputs reach reset values immediately; after release, a single payload 0xABC passes with one-cycle latency.
